// File: rtl/cpu_wb_master_if.sv
// Request/response and Wishbone classic signals of the CPU bus interface unit.
// The master modport is the unit itself; the slave modport is the core plus the bus.
interface cpu_wb_master_if #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 16,
  parameter int unsigned SW = 4
);
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_adr;
  logic [DW-1:0] req_data;
  logic [SW-1:0] req_sel;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic [AW-1:0] adr_out;
  logic [DW-1:0] data_out;
  logic [DW-1:0] data_in;
  logic          we;
  logic [SW-1:0] sel_out;
  logic          cyc_out;
  logic          stb_out;
  logic          ack_in;

  modport master (
    input  req_valid, req_we, req_adr, req_data, req_sel, data_in, ack_in,
    output req_ready, rsp_valid, rsp_data, rsp_err,
           adr_out, data_out, we, sel_out, cyc_out, stb_out
  );

  modport slave (
    output req_valid, req_we, req_adr, req_data, req_sel, data_in, ack_in,
    input  req_ready, rsp_valid, rsp_data, rsp_err,
           adr_out, data_out, we, sel_out, cyc_out, stb_out
  );
endinterface

// File: rtl/cpu_wb_master.sv
// Queues core load/store requests and issues them one at a time as Wishbone classic cycles.
// Optional watchdog abort (parameter TMO) is enabled by defining WB_TIMEOUT_EN.
module cpu_wb_master #(
  parameter int unsigned AW    = 16,
  parameter int unsigned DW    = 16,
  parameter int unsigned SW    = 4,
`ifdef WB_TIMEOUT_EN
  parameter int unsigned TMO   = 255,
`endif
  parameter int unsigned DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  cpu_wb_master_if.master   bus
);
  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned PW = IW + 1;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] data;
    logic [SW-1:0] sel;
  } req_t;

  typedef enum logic {IDLE, BUS} state_t;

  state_t        state_q, state_d;
  req_t          mem [DEPTH];
  req_t          head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          full, empty, push, pop, tmo_hit;

  logic          cyc_q, cyc_d, we_q, we_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [DW-1:0] data_q, data_d;
  logic [SW-1:0] sel_q, sel_d;
  logic          rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign push  = bus.req_valid && !full;
  assign head  = mem[rd_ptr[IW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[IW-1:0]] <= '{we: bus.req_we, adr: bus.req_adr,
                                       data: bus.req_data, sel: bus.req_sel};
  end

`ifdef WB_TIMEOUT_EN
  localparam int unsigned CW = ($clog2(TMO + 1) > 8) ? $clog2(TMO + 1) : 8;
  logic [CW-1:0] cnt_q;

  // Counts unacknowledged BUS cycles; held at zero while idle.
  always_ff @(posedge clk) begin
    if (reset || state_q == IDLE) cnt_q <= '0;
    else if (!bus.ack_in)         cnt_q <= cnt_q + CW'(1);
  end

  assign tmo_hit = (cnt_q == CW'(TMO));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      data_q      <= '0;
      sel_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      data_q      <= data_d;
      sel_q       <= sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    adr_d       = adr_q;
    data_d      = data_q;
    sel_d       = sel_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    pop         = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          state_d = BUS;
          cyc_d   = 1'b1;
          we_d    = head.we;
          adr_d   = head.adr;
          data_d  = head.data;
          sel_d   = head.sel;
        end
      end
      BUS: begin
        // An ack arriving on the watchdog's final cycle still completes normally.
        if (bus.ack_in) begin
          state_d     = IDLE;
          cyc_d       = 1'b0;
          pop         = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_data_d  = we_q ? '0 : bus.data_in;
          rsp_err_d   = 1'b0;
        end else if (tmo_hit) begin
          state_d     = IDLE;
          cyc_d       = 1'b0;
          pop         = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready = !full;
  assign bus.cyc_out   = cyc_q;
  assign bus.stb_out   = cyc_q;
  assign bus.we        = we_q;
  assign bus.adr_out   = adr_q;
  assign bus.data_out  = data_q;
  assign bus.sel_out   = sel_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
endmodule
